// File: rtl/dbb_rd_arbiter.sv
// Round-robin arbiter sharing the DBB AXI read port (AR + R) among NUM_REQ clients.
// Optional perf counters are enabled by defining DBB_RD_ARB_PERF_EN.

module dbb_rd_arb_cnt #(
  parameter int MAX_OUTST = 8
) (
  input  logic core_clk,
  input  logic rstn,
  input  logic inc,
  input  logic rlast_hs,
  output logic has_room,
  output logic underflow
);
  logic [3:0] cnt_q, cnt_d;
  logic       dec;

  always_comb begin
    dec       = rlast_hs && (cnt_q != 4'd0);
    underflow = rlast_hs && (cnt_q == 4'd0);
    cnt_d     = cnt_q;
    if (inc && !dec)      cnt_d = cnt_q + 4'd1;
    else if (dec && !inc) cnt_d = cnt_q - 4'd1;
  end

  assign has_room = cnt_q < 4'(MAX_OUTST);

  always_ff @(posedge core_clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

module dbb_rd_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int MAX_OUTST = 8
) (
  input  logic                        core_clk,
  input  logic                        rstn,
  input  logic [NUM_REQ-1:0]          req_ar_valid,
  output logic [NUM_REQ-1:0]          req_ar_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_ar_addr,
  input  logic [NUM_REQ*4-1:0]        req_ar_len,
  output logic [NUM_REQ-1:0]          req_r_valid,
  input  logic [NUM_REQ-1:0]          req_r_ready,
  output logic [DATA_W-1:0]           req_r_data,
  output logic                        req_r_last,
  output logic                        dbb_ar_valid,
  input  logic                        dbb_ar_ready,
  output logic [7:0]                  dbb_ar_id,
  output logic [ADDR_W-1:0]           dbb_ar_addr,
  output logic [3:0]                  dbb_ar_len,
  output logic [2:0]                  dbb_ar_size,
  input  logic                        dbb_r_valid,
  output logic                        dbb_r_ready,
  input  logic [7:0]                  dbb_r_id,
  input  logic                        dbb_r_last,
  input  logic [DATA_W-1:0]           dbb_r_data,
  output logic                        err_sticky
`ifdef DBB_RD_ARB_PERF_EN
  ,
  output logic [31:0]                 perf_ar_stall,
  output logic [31:0]                 perf_rd_beats
`endif
);
  localparam int IDX = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] elig, has_room, underflow, rlast_hs;
  logic [IDX-1:0]     ptr_q, ptr_d, win, id_q, id_d, rid_lo;
  logic               found, can_load, rid_legal;
  logic               full_q, full_d, err_q, err_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [3:0]         len_q, len_d;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    dbb_rd_arb_cnt #(.MAX_OUTST(MAX_OUTST)) u_cnt (
      .core_clk  (core_clk),
      .rstn      (rstn),
      .inc       (req_ar_ready[i]),
      .rlast_hs  (rlast_hs[i]),
      .has_room  (has_room[i]),
      .underflow (underflow[i])
    );
    assign elig[i] = req_ar_valid[i] & has_room[i];
  end

  // AR stage: a full slot may be refilled in the same cycle it drains.
  always_comb begin
    can_load = !full_q || dbb_ar_ready;
    found    = 1'b0;
    win      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && elig[(int'(ptr_q) + k) % NUM_REQ]) begin
        found = 1'b1;
        win   = IDX'((int'(ptr_q) + k) % NUM_REQ);
      end
    end
    req_ar_ready = '0;
    full_d       = full_q;
    id_d         = id_q;
    addr_d       = addr_q;
    len_d        = len_q;
    ptr_d        = ptr_q;
    if (can_load) begin
      full_d = found;
      if (found) begin
        req_ar_ready[win] = 1'b1;
        id_d   = win;
        addr_d = req_ar_addr[win*ADDR_W +: ADDR_W];
        len_d  = req_ar_len[win*4 +: 4];
        ptr_d  = (int'(win) == NUM_REQ - 1) ? '0 : win + IDX'(1);
      end
    end
  end

  // R routing; beats with an unknown id are swallowed so the bus never stalls.
  assign rid_lo    = dbb_r_id[IDX-1:0];
  assign rid_legal = (dbb_r_id[7:IDX] == '0) && (int'(rid_lo) < NUM_REQ);

  always_comb begin
    req_r_valid = '0;
    rlast_hs    = '0;
    dbb_r_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rid_legal && int'(rid_lo) == i) begin
        req_r_valid[i] = dbb_r_valid;
        dbb_r_ready    = req_r_ready[i];
        rlast_hs[i]    = dbb_r_valid & req_r_ready[i] & dbb_r_last;
      end
    end
    err_d = err_q | (dbb_r_valid & ~rid_legal) | (|underflow);
  end

  always_ff @(posedge core_clk or negedge rstn) begin
    if (!rstn) begin
      full_q <= 1'b0;
      id_q   <= '0;
      addr_q <= '0;
      len_q  <= '0;
      ptr_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      full_q <= full_d;
      id_q   <= id_d;
      addr_q <= addr_d;
      len_q  <= len_d;
      ptr_q  <= ptr_d;
      err_q  <= err_d;
    end
  end

  assign dbb_ar_valid = full_q;
  assign dbb_ar_id    = {{(8-IDX){1'b0}}, id_q};
  assign dbb_ar_addr  = addr_q;
  assign dbb_ar_len   = len_q;
  assign dbb_ar_size  = 3'b011;
  assign req_r_data   = dbb_r_data;
  assign req_r_last   = dbb_r_last;
  assign err_sticky   = err_q;

`ifdef DBB_RD_ARB_PERF_EN
  logic [31:0] stall_q, stall_d, beats_q, beats_d;

  always_comb begin
    stall_d = stall_q;
    beats_d = beats_q;
    if (full_q && !dbb_ar_ready && stall_q != 32'hFFFF_FFFF) stall_d = stall_q + 32'd1;
    if (dbb_r_valid && dbb_r_ready && beats_q != 32'hFFFF_FFFF) beats_d = beats_q + 32'd1;
  end

  always_ff @(posedge core_clk or negedge rstn) begin
    if (!rstn) begin
      stall_q <= '0;
      beats_q <= '0;
    end else begin
      stall_q <= stall_d;
      beats_q <= beats_d;
    end
  end

  assign perf_ar_stall = stall_q;
  assign perf_rd_beats = beats_q;
`endif
endmodule

// File: tb/tb_dbb_rd_arbiter.sv
// Self-checking bench for dbb_rd_arbiter: directed phases plus random traffic
// compared each cycle against a behavioural model of the arbitration rules.

module tb_dbb_rd_arbiter;
  localparam int N  = 2;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int MO = 8;

  logic              core_clk = 1'b0;
  logic              rstn;
  logic [N-1:0]      req_ar_valid, req_ar_ready, req_r_valid, req_r_ready;
  logic [N*AW-1:0]   req_ar_addr;
  logic [N*4-1:0]    req_ar_len;
  logic [DW-1:0]     req_r_data, dbb_r_data;
  logic              req_r_last, dbb_ar_valid, dbb_ar_ready, dbb_r_valid, dbb_r_ready;
  logic              dbb_r_last, err_sticky;
  logic [7:0]        dbb_ar_id, dbb_r_id;
  logic [AW-1:0]     dbb_ar_addr;
  logic [3:0]        dbb_ar_len;
  logic [2:0]        dbb_ar_size;

  always #5 core_clk = ~core_clk;

  dbb_rd_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(MO)) dut (
    .core_clk(core_clk), .rstn(rstn),
    .req_ar_valid(req_ar_valid), .req_ar_ready(req_ar_ready),
    .req_ar_addr(req_ar_addr), .req_ar_len(req_ar_len),
    .req_r_valid(req_r_valid), .req_r_ready(req_r_ready),
    .req_r_data(req_r_data), .req_r_last(req_r_last),
    .dbb_ar_valid(dbb_ar_valid), .dbb_ar_ready(dbb_ar_ready),
    .dbb_ar_id(dbb_ar_id), .dbb_ar_addr(dbb_ar_addr), .dbb_ar_len(dbb_ar_len),
    .dbb_ar_size(dbb_ar_size),
    .dbb_r_valid(dbb_r_valid), .dbb_r_ready(dbb_r_ready), .dbb_r_id(dbb_r_id),
    .dbb_r_last(dbb_r_last), .dbb_r_data(dbb_r_data),
    .err_sticky(err_sticky)
  );

  // Reference model state
  int            m_cnt[N];
  int            m_ptr;
  bit            m_full, m_err;
  int            m_id;
  logic [AW-1:0] m_addr;
  logic [3:0]    m_len;
  logic [N-1:0]  last_rdy;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (req_ar_valid[j] && m_cnt[j] < MO) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_ptr = 0; m_full = 0; m_err = 0; m_id = 0; m_addr = '0; m_len = '0;
  endtask

  task automatic rand_addr();
    for (int i = 0; i < N; i++) begin
      req_ar_addr[i*AW +: AW] = {$urandom, $urandom};
      req_ar_len[i*4 +: 4]    = 4'($urandom_range(0, 15));
    end
  endtask

  task automatic r_idle();
    dbb_r_valid = 0; dbb_r_id = '0; dbb_r_last = 0; dbb_r_data = '0; req_r_ready = '0;
  endtask

  // One clock: check combinational outputs before the edge, update model, check registers after.
  task automatic step();
    int w, rid;
    bit can_load, legal;
    logic [N-1:0] exp_rdy, exp_rv;
    logic exp_rr;
    #1;
    can_load = !m_full || dbb_ar_ready;
    w = can_load ? pick() : -1;
    exp_rdy = '0;
    if (w >= 0) exp_rdy[w] = 1'b1;
    rid = int'(dbb_r_id);
    legal = rid < N;
    exp_rv = '0;
    if (dbb_r_valid && legal) exp_rv[rid] = 1'b1;
    exp_rr = legal ? req_r_ready[rid] : 1'b1;
    last_rdy = req_ar_ready;
    chk("req_ar_ready", req_ar_ready, exp_rdy);
    chk("req_r_valid", req_r_valid, exp_rv);
    chk("dbb_r_ready", dbb_r_ready, exp_rr);
    if (dbb_r_valid) begin
      chk("req_r_data", req_r_data, dbb_r_data);
      chk("req_r_last", req_r_last, dbb_r_last);
    end
    @(posedge core_clk);
    if (dbb_r_valid) begin
      if (!legal) m_err = 1;
      else if (req_r_ready[rid] && dbb_r_last) begin
        if (m_cnt[rid] == 0) m_err = 1;
        else m_cnt[rid]--;
      end
    end
    if (can_load) begin
      if (w >= 0) begin
        m_cnt[w]++;
        m_full = 1; m_id = w;
        m_addr = req_ar_addr[w*AW +: AW];
        m_len  = req_ar_len[w*4 +: 4];
        m_ptr  = (w + 1) % N;
      end else m_full = 0;
    end
    #1;
    chk("dbb_ar_valid", dbb_ar_valid, m_full);
    if (m_full) begin
      chk("dbb_ar_id", dbb_ar_id, 64'(m_id));
      chk("dbb_ar_addr", dbb_ar_addr, m_addr);
      chk("dbb_ar_len", dbb_ar_len, m_len);
    end
    chk("err_sticky", err_sticky, m_err);
  endtask

  task automatic do_reset();
    rstn = 0;
    req_ar_valid = '0; req_ar_addr = '0; req_ar_len = '0; dbb_ar_ready = 0;
    r_idle();
    model_reset();
    @(posedge core_clk); @(posedge core_clk);
    #1;
    chk("rst_ar_valid", dbb_ar_valid, 0);
    chk("rst_ar_id", dbb_ar_id, 0);
    chk("rst_ar_addr", dbb_ar_addr, 0);
    chk("rst_ar_len", dbb_ar_len, 0);
    chk("rst_err", err_sticky, 0);
    chk("rst_ar_ready", req_ar_ready, 0);
    rstn = 1;
    #1;
  endtask

  logic [7:0]    ids[4];
  logic [AW-1:0] hold_addr;
  logic [3:0]    hold_len;
  logic [7:0]    hold_id;
  bit            regrant;
  int            acc, rr;

  initial begin
    do_reset();
    chk("ar_size", dbb_ar_size, 3'b011);

    // Idle after reset
    for (int k = 0; k < 3; k++) step();

    // Round robin, full throughput
    req_ar_valid = '1; dbb_ar_ready = 1;
    for (int k = 0; k < 4; k++) begin
      rand_addr();
      step();
      ids[k] = dbb_ar_id;
    end
    chk("rr_id0", ids[0], 0);
    chk("rr_id1", ids[1], 1);
    chk("rr_id2", ids[2], 0);
    chk("rr_id3", ids[3], 1);

    // Stall while FULL
    dbb_ar_ready = 0;
    hold_addr = dbb_ar_addr; hold_len = dbb_ar_len; hold_id = dbb_ar_id;
    for (int k = 0; k < 5; k++) begin
      rand_addr();
      step();
      chk("stall_addr", dbb_ar_addr, hold_addr);
      chk("stall_len", dbb_ar_len, hold_len);
      chk("stall_id", dbb_ar_id, hold_id);
      chk("stall_rdy", last_rdy, 0);
    end
    dbb_ar_ready = 1;
    rand_addr();
    step();
    chk("resume_id", dbb_ar_id, 0);

    // Drive requester 0 to its outstanding limit
    req_ar_valid = 2'b01;
    for (int k = 0; k < 20 && m_cnt[0] < MO; k++) begin
      rand_addr();
      step();
    end
    req_ar_valid = 2'b11;
    rand_addr();
    step();
    chk("limit_block", last_rdy, 2'b10);
    dbb_r_valid = 1; dbb_r_id = 8'd0; dbb_r_last = 1; req_r_ready = 2'b01;
    dbb_r_data = {$urandom, $urandom};
    step();
    r_idle();
    regrant = 0;
    for (int k = 0; k < 4 && !regrant; k++) begin
      step();
      regrant = last_rdy[0];
    end
    chk("limit_regrant", regrant, 1);

    // Burst of 4 beats to requester 1 with toggling ready
    req_ar_valid = '0;
    acc = 0;
    for (int k = 0; k < 12 && acc < 4; k++) begin
      dbb_r_valid = 1; dbb_r_id = 8'd1; dbb_r_last = (acc == 3);
      dbb_r_data = {$urandom, $urandom};
      req_r_ready = {k[0], 1'b1};
      step();
      if (req_r_ready[1]) acc++;
    end
    chk("burst_beats", acc, 4);
    r_idle();

    // Random traffic, legal ids only
    for (int k = 0; k < 400; k++) begin
      req_ar_valid = N'($urandom);
      rand_addr();
      dbb_ar_ready = ($urandom_range(0, 3) != 0);
      dbb_r_valid = $urandom_range(0, 1);
      rr = $urandom_range(0, N - 1);
      dbb_r_id = 8'(rr);
      dbb_r_last = (m_cnt[rr] > 0) && ($urandom_range(0, 1) == 1);
      dbb_r_data = {$urandom, $urandom};
      req_r_ready = N'($urandom);
      step();
    end
    r_idle();

    // Underflow: rlast with nothing outstanding
    do_reset();
    dbb_r_valid = 1; dbb_r_id = 8'd0; dbb_r_last = 1; req_r_ready = 2'b01;
    step();
    r_idle();
    chk("underflow_err", err_sticky, 1);
    req_ar_valid = 2'b01; dbb_ar_ready = 1;
    for (int k = 0; k < 12; k++) begin
      rand_addr();
      step();
    end

    // Illegal RID
    do_reset();
    dbb_r_valid = 1; dbb_r_id = 8'h05; dbb_r_last = 0; req_r_ready = '0;
    dbb_r_data = {$urandom, $urandom};
    step();
    r_idle();
    chk("illegal_err", err_sticky, 1);
    for (int k = 0; k < 5; k++) step();
    chk("err_hold", err_sticky, 1);
    do_reset();
    chk("err_cleared", err_sticky, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
